alu_operand_seq: RTL and testbench
==================================

Name: alu_operand_seq

Overview:
- Upstream input stage for the 4-bit ALU.
- Turns one shared 4-bit switch bank plus two push-buttons into a committed operand/opcode triple (a, b, op) that drives the ALU's combinational inputs.
- Synchronizes and debounces the buttons, then steps a small entry FSM: A, then B, then OP.
- Commits all three values atomically, so the ALU never sees a half-entered operation.

Parameters:
- DB_CYCLES, default 1000000, consecutive stable cycles required before a debounced button level changes (20 ms at 50 MHz). Must be >= 1.
- DB_CNT_W, default 20, width of the debounce counter. Must satisfy 2^DB_CNT_W > DB_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sw  in  4  shared data switches (asynchronous to clk)
- btn_enter  in  1  enter button, active-high, asynchronous and bouncy
- btn_clr  in  1  abort-entry button, active-high, asynchronous and bouncy
- a_o  out  4  committed operand A to ALU
- b_o  out  4  committed operand B to ALU
- op_o  out  3  committed opcode to ALU (000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 less-than, 111 equal)
- valid_o  out  1  high once at least one triple has been committed since reset
- upd_o  out  1  one-cycle pulse, coincident with the first cycle new a_o/b_o/op_o are visible
- state_o  out  2  current entry state, for LEDs (00 S_A, 01 S_B, 10 S_OP)

Behaviour:
- Reset (rst_n low, asynchronous):
  - a_o, b_o, op_o = 0; valid_o = 0; upd_o = 0; state = S_A.
  - Shadow registers, synchronizers and debounce counters clear; debounced levels clear to 0.
  - Reset during entry discards the partial entry.
- Button conditioning, per button, identical:
  - Two-flop synchronizer.
  - Debounce: the counter increments while the synchronized level differs from the debounced level and clears whenever they agree.
  - When the counter reaches DB_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - A glitch shorter than DB_CYCLES cycles produces no change.
  - Press pulse = debounced AND NOT debounced_q (registered copy); exactly one cycle per press.
  - Releases produce no pulse.
  - Latency from pin rise to press pulse: 2 + DB_CYCLES + 1 cycles.
- FSM, with enter pulse (ep) and clear pulse (cp):
  - S_A: ep -> a_sh <= sw; go to S_B.
  - S_B: ep -> b_sh <= sw; go to S_OP.
  - S_OP: ep -> a_o <= a_sh, b_o <= b_sh, op_o <= sw[2:0]; valid_o <= 1; upd_o <= 1 for the next cycle only; go to S_A.
  - sw[3] is ignored in S_OP.
  - cp in any state -> S_A; shadow contents are don't-care and committed outputs are unchanged.
  - cp and ep in the same cycle: cp wins; nothing is captured.
  - Illegal state encoding 11 -> S_A on the next edge, with no output change.
- Committed outputs hold across new entries; they change only on an S_OP commit or reset.
- sw is sampled directly, without a synchronizer. The user holds the switches stable while pressing, and the debounce latency guarantees settling.
- No arithmetic in this block; widths pass through unchanged.

Optional Feature:
- ALU_OPERAND_SEQ_DEBOUNCE_EN
- Defined: debounce counters present, as described above.
- Undefined: counters removed; debounced level = synchronized level, so press-pulse latency is 3 cycles; DB_CYCLES and DB_CNT_W are unused. Intended for simulation and benches that drive clean buttons.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD..OP_EQ (3-bit)
  - entry-state typedef/constants S_A = 2'b00, S_B = 2'b01, S_OP = 2'b10
  - operand width constant DW = 4
- One sub-module, btn_cond: synchronizer, debounce and rising-edge pulse, with parameters DB_CYCLES and DB_CNT_W. Instantiated twice (enter, clr). The macro is honoured inside it.

Test Plan (DB_CYCLES=4 unless noted):
- Reset then entry: release reset; sw=5, press enter; sw=3, press enter; sw=0001, press enter.
  - Required: a_o=5, b_o=3, op_o=001, valid_o=1.
  - upd_o is high for exactly one cycle, coincident with the new outputs.
  - state_o sequence: 00 -> 01 -> 10 -> 00.
- Bounce rejection: enter pulses high for 3 cycles, low for 2, high for 3.
  - Required: no press pulse, state_o stays 00.
  - Then hold high for 6 cycles: exactly one pulse, 7 cycles after the rising edge.
- Abort: enter A=9 and B=2, press clr.
  - Required: state_o=00; outputs keep the previous triple; upd_o stays 0.
  - A full new entry then commits only the new values.
- Simultaneous press: in S_B, enter and clr rise on the same cycle and stay clean.
  - Required: state_o=00, b_sh not captured, no upd_o.
- Async reset mid-entry: assert rst_n low at S_OP between clock edges.
  - Required: all outputs 0 immediately (before the next clk edge), state_o=00.
- Macro undefined: a clean enter press yields a pulse 3 cycles after the rise; a 1-cycle glitch yields a pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the 4-bit ALU front end: operand width, opcodes and entry-FSM states.
package alu_pkg;

  localparam int DW = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_LT  = 3'b110,
    OP_EQ  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    S_A  = 2'b00,
    S_B  = 2'b01,
    S_OP = 2'b10
  } entry_state_t;

endpackage

// File: rtl/alu_operand_seq_btn_cond.sv
// Button conditioner: two-flop synchronizer, optional debounce, registered press pulse.
// Debounce counter is present only when ALU_OPERAND_SEQ_DEBOUNCE_EN is defined.
module btn_cond #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_CNT_W  = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic sync1, sync2;
  logic level, level_q;

  if (DB_CYCLES < 1 || DB_CNT_W < 1 || DB_CNT_W > 30 || DB_CYCLES >= (2 ** DB_CNT_W)) begin : g_param_chk
    $error("btn_cond: DB_CYCLES must be >= 1 and fit in DB_CNT_W bits");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef ALU_OPERAND_SEQ_DEBOUNCE_EN
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);
  logic [DB_CNT_W-1:0] cnt;

  // The level flips on the DB_CYCLES-th consecutive cycle of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/alu_operand_seq.sv
// Operand/opcode entry sequencer for the 4-bit ALU; commits (a, b, op) atomically.
// Build option: ALU_OPERAND_SEQ_DEBOUNCE_EN enables button debounce counters.
module alu_operand_seq
  import alu_pkg::*;
#(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_CNT_W  = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] sw,
  input  logic          btn_enter,
  input  logic          btn_clr,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic [2:0]    op_o,
  output logic          valid_o,
  output logic          upd_o,
  output logic [1:0]    state_o
);

  logic enter_p, clr_p;
  logic [DW-1:0] a_sh, b_sh;
  entry_state_t state;

  btn_cond #(.DB_CYCLES(DB_CYCLES), .DB_CNT_W(DB_CNT_W)) u_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_enter),
    .press (enter_p)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES), .DB_CNT_W(DB_CNT_W)) u_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .press (clr_p)
  );

  assign state_o = state;

  // Clear has priority over enter; committed outputs only move on an S_OP commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_A;
      a_sh    <= '0;
      b_sh    <= '0;
      a_o     <= '0;
      b_o     <= '0;
      op_o    <= '0;
      valid_o <= 1'b0;
      upd_o   <= 1'b0;
    end else begin
      upd_o <= 1'b0;
      if (clr_p) begin
        state <= S_A;
      end else begin
        case (state)
          S_A: if (enter_p) begin
            a_sh  <= sw;
            state <= S_B;
          end
          S_B: if (enter_p) begin
            b_sh  <= sw;
            state <= S_OP;
          end
          S_OP: if (enter_p) begin
            a_o     <= a_sh;
            b_o     <= b_sh;
            op_o    <= sw[2:0];
            valid_o <= 1'b1;
            upd_o   <= 1'b1;
            state   <= S_A;
          end
          default: state <= S_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_seq.sv
// Scoreboard bench for alu_operand_seq: stimulus pushes expected commits, a monitor checks them on upd_o.
module tb_alu_operand_seq;

  localparam int DB = 4;
`ifdef ALU_OPERAND_SEQ_DEBOUNCE_EN
  localparam int LAT = 2 + DB + 1;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       btn_enter = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] a_o, b_o;
  logic [2:0] op_o;
  logic       valid_o, upd_o;
  logic [1:0] state_o;

  alu_operand_seq #(.DB_CYCLES(DB), .DB_CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_clr   (btn_clr),
    .a_o       (a_o),
    .b_o       (b_o),
    .op_o      (op_o),
    .valid_o   (valid_o),
    .upd_o     (upd_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } triple_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int updCount = 0;
  int pulseCount = 0;
  int lastPulseCyc = 0;
  triple_t expQ[$];
  triple_t model = '0;
  triple_t prevOut = '0;
  logic modelValid = 1'b0;
  logic prevUpd = 1'b0;

  function automatic triple_t mk(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    triple_t t;
    t.a = a;
    t.b = b;
    t.op = op;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] val, input logic enter, input logic clr);
    @(negedge clk);
    sw = val;
    btn_enter = enter;
    btn_clr = clr;
    repeat (LAT + 1) @(negedge clk);
    btn_enter = 1'b0;
    btn_clr = 1'b0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && dut.enter_p) begin
      pulseCount++;
      lastPulseCyc = cyc;
    end
  end

  // Monitor: pops an expected triple on every upd_o, otherwise checks outputs hold.
  always @(negedge clk) begin
    triple_t cur;
    triple_t exp;
    if (!rst_n) begin
      model = '0;
      modelValid = 1'b0;
      prevOut = '0;
      prevUpd = 1'b0;
    end else begin
      cur = mk(a_o, b_o, op_o);
      if (upd_o) begin
        updCount++;
        checkOutput("upd_single_cycle", 32'(prevUpd), 32'd0);
        checkOutput("upd_expected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          exp = expQ.pop_front();
          checkOutput("commit_triple", 32'(cur), 32'(exp));
          checkOutput("commit_valid", 32'(valid_o), 32'd1);
          checkOutput("upd_coincident", 32'(prevOut), 32'(model));
          model = exp;
          modelValid = 1'b1;
        end
      end else begin
        checkOutput("hold_triple", 32'(cur), 32'(model));
        checkOutput("hold_valid", 32'(valid_o), 32'(modelValid));
      end
      prevOut = cur;
      prevUpd = upd_o;
    end
  end

  initial begin
    int p0, u0, riseCyc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_a", 32'(a_o), 32'd0);
    checkOutput("reset_b", 32'(b_o), 32'd0);
    checkOutput("reset_op", 32'(op_o), 32'd0);
    checkOutput("reset_valid", 32'(valid_o), 32'd0);
    checkOutput("reset_upd", 32'(upd_o), 32'd0);
    checkOutput("reset_state", 32'(state_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic entry");
    applyStimulus(4'd5, 1'b1, 1'b0);
    checkOutput("entry_state_b", 32'(state_o), 32'd1);
    applyStimulus(4'd3, 1'b1, 1'b0);
    checkOutput("entry_state_op", 32'(state_o), 32'd2);
    expQ.push_back(mk(4'd5, 4'd3, 3'b001));
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("entry_state_a", 32'(state_o), 32'd0);
    checkOutput("entry_a", 32'(a_o), 32'd5);
    checkOutput("entry_b", 32'(b_o), 32'd3);
    checkOutput("entry_op", 32'(op_o), 32'd1);
    checkOutput("entry_valid", 32'(valid_o), 32'd1);
    checkOutput("entry_upd_count", 32'(updCount), 32'd1);

    p0 = pulseCount;
`ifdef ALU_OPERAND_SEQ_DEBOUNCE_EN
    $display("[TB] bounce rejection");
    @(negedge clk);
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    btn_enter = 1'b0;
    repeat (2) @(negedge clk);
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    btn_enter = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    checkOutput("bounce_no_pulse", 32'(pulseCount - p0), 32'd0);
    checkOutput("bounce_state", 32'(state_o), 32'd0);
    btn_enter = 1'b1;
    riseCyc = cyc;
    repeat (6) @(negedge clk);
    btn_enter = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    checkOutput("hold_one_pulse", 32'(pulseCount - p0), 32'd1);
    checkOutput("hold_pulse_latency", 32'(lastPulseCyc - riseCyc), 32'(LAT));
`else
    $display("[TB] undebounced glitch");
    @(negedge clk);
    btn_enter = 1'b1;
    riseCyc = cyc;
    @(negedge clk);
    btn_enter = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    checkOutput("glitch_one_pulse", 32'(pulseCount - p0), 32'd1);
    checkOutput("glitch_pulse_latency", 32'(lastPulseCyc - riseCyc), 32'd3);
`endif
    checkOutput("pulse_state_b", 32'(state_o), 32'd1);
    applyStimulus(4'd0, 1'b0, 1'b1);
    checkOutput("pulse_clr_state", 32'(state_o), 32'd0);

    $display("[TB] abort");
    applyStimulus(4'd9, 1'b1, 1'b0);
    applyStimulus(4'd2, 1'b1, 1'b0);
    checkOutput("abort_pre_state", 32'(state_o), 32'd2);
    u0 = updCount;
    applyStimulus(4'd0, 1'b0, 1'b1);
    checkOutput("abort_state", 32'(state_o), 32'd0);
    checkOutput("abort_keep_a", 32'(a_o), 32'd5);
    checkOutput("abort_keep_b", 32'(b_o), 32'd3);
    checkOutput("abort_keep_op", 32'(op_o), 32'd1);
    checkOutput("abort_no_upd", 32'(updCount - u0), 32'd0);
    applyStimulus(4'd6, 1'b1, 1'b0);
    applyStimulus(4'hA, 1'b1, 1'b0);
    expQ.push_back(mk(4'd6, 4'hA, 3'b101));
    applyStimulus(4'b1101, 1'b1, 1'b0);
    checkOutput("reentry_a", 32'(a_o), 32'd6);
    checkOutput("reentry_b", 32'(b_o), 32'hA);
    checkOutput("reentry_op_sw3_ignored", 32'(op_o), 32'd5);

    $display("[TB] simultaneous enter and clear");
    applyStimulus(4'd7, 1'b1, 1'b0);
    checkOutput("simul_pre_state", 32'(state_o), 32'd1);
    u0 = updCount;
    applyStimulus(4'hF, 1'b1, 1'b1);
    checkOutput("simul_state", 32'(state_o), 32'd0);
    checkOutput("simul_b_sh_kept", 32'(dut.b_sh), 32'hA);
    checkOutput("simul_no_upd", 32'(updCount - u0), 32'd0);

    $display("[TB] async reset mid-entry");
    applyStimulus(4'd8, 1'b1, 1'b0);
    applyStimulus(4'd4, 1'b1, 1'b0);
    checkOutput("areset_pre_state", 32'(state_o), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_a", 32'(a_o), 32'd0);
    checkOutput("areset_b", 32'(b_o), 32'd0);
    checkOutput("areset_op", 32'(op_o), 32'd0);
    checkOutput("areset_valid", 32'(valid_o), 32'd0);
    checkOutput("areset_state", 32'(state_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(4'd2, 1'b1, 1'b0);
    applyStimulus(4'hC, 1'b1, 1'b0);
    expQ.push_back(mk(4'd2, 4'hC, 3'b111));
    applyStimulus(4'b0111, 1'b1, 1'b0);
    checkOutput("post_reset_valid", 32'(valid_o), 32'd1);
    checkOutput("post_reset_a", 32'(a_o), 32'd2);

    repeat (2) @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("total_commits", 32'(updCount), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
